if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the IF_ID register and the decode stage.
- Keeps the architectural fetch PC and fetches 32-bit instructions through a direct-mapped instruction cache.
- On a miss, refills the cache from the byte-wide memory controller, 4 bytes little-endian.
- Applies static branch prediction and emits pc / instruction / prediction to IF_ID. EX mispredict redirects restart fetch.

Parameters:
- ICACHE_INDEX_BITS, 6: log2 of line count (64 lines, one 32-bit word per line).
- RESET_PC, 32'h0: fetch PC after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- stall_in  input  1  stall-bus request for IF to hold (from ID load-use stall)
- br_flag  input  1  EX redirect: fetch must restart at br_target
- br_target  input  32  redirect PC
- mem_req  output  1  byte-read request to memory controller
- mem_addr  output  32  byte address of current request
- mem_valid  input  1  mem_data holds the byte for the mem_addr presented in the previous cycle
- mem_data  input  8  returned byte
- if_valid  output  1  if_pc / if_instruction / if_prediction valid for IF_ID
- if_pc  output  32  PC of emitted instruction
- if_instruction  output  32  emitted instruction word
- if_prediction  output  1  1 = predicted taken

Behaviour:
- Reset (rst==0 at clk edge):
  - pc=RESET_PC; state=LOOKUP; cnt=0.
  - All cache valid bits = 0.
  - Outputs: mem_req=0, mem_addr=0, if_valid=0, if_pc=0, if_instruction=0, if_prediction=0.
  - Reset mid-refill abandons the refill; no cache write.
- Cache lookup:
  - index = pc[ICACHE_INDEX_BITS+1:2]; tag = pc[31:ICACHE_INDEX_BITS+2].
  - pc[1:0] is ignored.
  - hit = line valid and tag match.
- Static prediction (combinational on the hit word):
  - opcode 1101111 (JAL): next = pc + J_imm, pred = 1.
  - opcode 1100011 with word[31]==1 (backward branch): next = pc + B_imm, pred = 1.
  - Everything else, JALR included: next = pc + 4, pred = 0.
- State LOOKUP, priority order per cycle:
  1. br_flag: pc <= br_target; if_valid <= 0.
  2. stall_in: pc and all if_* outputs hold.
  3. hit: if_valid <= 1; if_pc <= pc; if_instruction <= word; if_prediction <= pred; pc <= next. One-cycle hit latency, one instruction per cycle sustained.
  4. miss: if_valid <= 0; state <= MISS; cnt <= 0; mem_req <= 1; mem_addr <= {pc[31:2],2'b00}.
- State MISS:
  - mem_req stays 1. mem_addr = {pc[31:2],2'b00} + the number of bytes requested so far, advancing one byte per cycle.
  - Each mem_valid: buffer[8*cnt +: 8] <= mem_data; cnt++.
  - After the 4th byte: write buffer to the line, set tag and valid; mem_req <= 0; state <= LOOKUP.
  - The next LOOKUP then hits and emits. Miss penalty is therefore fill time plus one cycle.
  - stall_in during MISS: refill continues; if_* outputs hold.
  - br_flag during MISS: refill aborted; no cache write; mem_req <= 0; cnt <= 0; pc <= br_target; if_valid <= 0; state <= LOOKUP.
  - mem_valid while mem_req==0 is ignored.
- Simultaneous br_flag and stall_in: redirect wins.
- PC arithmetic is mod 2^32; wrap-around needs no special case.
- Tag/index aliasing: a refill overwrites the line unconditionally.

Test Plan:
- Reset then cold miss at PC 0; memory returns 0x93, 0x00, 0x10, 0x00 at addresses 0..3 -> 4 byte requests, then if_valid=1, if_pc=0, if_instruction=0x00100093, if_prediction=0, next fetch pc=4.
- Loop re-fetching PC 0 after a redirect br_target=0 -> no mem_req; the emit arrives 1 cycle after the redirect is consumed.
- Word 0xFE000CE3 (beq x0,x0,-8) at PC 8 -> if_prediction=1, following if_pc=0. Forward beq 0x00000463 -> pred=0, next pc=12.
- JAL 0x0100006F at PC 0x10 -> if_prediction=1, next if_pc=0x20.
- br_flag=1, br_target=0x100 after 2 bytes of a refill -> mem_req=0 next cycle, line not written, the old PC re-misses later; next fetch at 0x100.
- stall_in held 3 cycles with if_valid=1 -> if_* unchanged, no PC advance. stall_in with br_flag -> redirect taken. rst=0 mid-refill -> all outputs 0 and cache invalidated.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the fetch PC, looks it up in a direct-mapped
// one-word-per-line instruction cache, refills misses one byte per cycle from
// the memory controller (little-endian) and applies static branch prediction
// before handing pc / instruction / prediction to the IF_ID register.
module if_stage #(
  parameter int unsigned ICACHE_INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC          = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_prediction
);

  localparam int unsigned LINES = 1 << ICACHE_INDEX_BITS;
  localparam int unsigned TAG_W = 30 - ICACHE_INDEX_BITS;

  localparam logic [0:0] ST_LOOKUP = 1'b0;
  localparam logic [0:0] ST_MISS   = 1'b1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] fill_buf_q, fill_buf_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_pred_q, if_pred_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [ICACHE_INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]             tag;
  logic                         hit;
  logic [31:0]                  word;
  logic [31:0]                  j_imm;
  logic [31:0]                  b_imm;
  logic [31:0]                  next_pc;
  logic                         pred;
  logic                         fill_we;
  logic [31:0]                  fill_word;

  assign idx  = pc_q[ICACHE_INDEX_BITS+1:2];
  assign tag  = pc_q[31:ICACHE_INDEX_BITS+2];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign word = data_q[idx];

  assign j_imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
  assign b_imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};

  // The 4th byte goes straight from the bus into the line, so the
  // buffer only needs to hold the first three.
  assign fill_word = {mem_data, fill_buf_q};

  // Static prediction: JAL and backward conditional branches are taken.
  always_comb begin
    next_pc = pc_q + 32'd4;
    pred    = 1'b0;
    if (word[6:0] == OP_JAL) begin
      next_pc = pc_q + j_imm;
      pred    = 1'b1;
    end else if (word[6:0] == OP_BRANCH && word[31]) begin
      next_pc = pc_q + b_imm;
      pred    = 1'b1;
    end
  end

  // Fetch / refill control: redirect > stall > hit > miss in LOOKUP;
  // in MISS only a redirect interrupts the refill.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    fill_buf_d = fill_buf_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_pred_d  = if_pred_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    case (state_q)
      ST_LOOKUP: begin
        if (br_flag) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (stall_in) begin
          pc_d = pc_q;
        end else if (hit) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = word;
          if_pred_d  = pred;
          pc_d       = next_pc;
        end else begin
          if_valid_d = 1'b0;
          state_d    = ST_MISS;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_q[31:2], 2'b00};
        end
      end
      ST_MISS: begin
        if (br_flag) begin
          mem_req_d  = 1'b0;
          cnt_d      = '0;
          pc_d       = br_target;
          if_valid_d = 1'b0;
          state_d    = ST_LOOKUP;
        end else begin
          // Request address walks the four bytes of the line, one per
          // cycle, then parks on the last byte until it returns.
          if (mem_addr_q[1:0] != 2'b11) begin
            mem_addr_d = mem_addr_q + 32'd1;
          end
          if (mem_valid && mem_req_q) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0: fill_buf_d[7:0]   = mem_data;
              2'd1: fill_buf_d[15:8]  = mem_data;
              2'd2: fill_buf_d[23:16] = mem_data;
              default: begin
                fill_we      = 1'b1;
                valid_d[idx] = 1'b1;
                mem_req_d    = 1'b0;
                state_d      = ST_LOOKUP;
              end
            endcase
          end
        end
      end
      default: state_d = ST_LOOKUP;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_LOOKUP;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      fill_buf_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_pred_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      fill_buf_q <= fill_buf_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_pred_q  <= if_pred_d;
      valid_q    <= valid_d;
    end
  end

  // Cache tag/data arrays; written only on refill completion outside reset.
  always_ff @(posedge clk) begin
    if (rst && fill_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_word;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign if_prediction  = if_pred_q;

endmodule
